fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter MAX_OUTSTANDING, fixed at 2, meaning in-flight requests plus buffered instructions.
REQ-003 SHALL have ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  instruction memory accepts request.
- imem_req_addr  out  32  fetch address.
- imem_rsp_valid  in  1  instruction word returned; in order, at least 1 cycle after acceptance, never back-pressured.
- imem_rsp_data  in  32  returned instruction word.
- redirect_valid  in  1  branch/jump redirect, single-cycle pulse.
- redirect_pc  in  32  redirect target, word aligned.
- f_valid  out  1  f_instr/f_pc valid toward IF/ID register.
- f_ready  in  1  IF/ID register enable; pop when f_valid and f_ready.
- f_instr  out  32  fetched instruction.
- f_pc  out  32  address of f_instr.

Function
REQ-004 SHALL hold pc register (next request address), 2-entry in-flight address FIFO, 2-entry output FIFO {instr, pc}, stale counter 0..2, and FSM {BOOT, RUN, FLUSH}.
REQ-005 BOOT: one cycle after reset release, no request; always -> RUN.
REQ-006 RUN: imem_req_valid=1 iff inflight + out_count < 2; imem_req_addr=pc.
REQ-007 On request handshake, SHALL push pc to in-flight FIFO; pc <= pc+4, modulo 2^32 (32'hFFFF_FFFC wraps to 32'h0).
REQ-008 On imem_rsp_valid with stale==0, SHALL pop in-flight FIFO and push {imem_rsp_data, popped addr} into output FIFO the same edge.
REQ-009 f_valid=1 iff output FIFO non-empty; f_instr/f_pc SHALL be its head and stay stable while f_valid and not f_ready.
REQ-010 Output push and pop in the same cycle SHALL both take effect; the credit rule guarantees no overflow; a push into a full FIFO is an assertion failure.
REQ-011 Minimum latency: request accepted in cycle N, response in N+1 -> f_valid in N+2.
REQ-012 Redirect, in any state, SHALL: pc <= redirect_pc; clear output FIFO; stale <= in-flight count including any request handshaken the same cycle; clear in-flight FIFO.
REQ-013 Redirect: if new stale > 0 -> FLUSH, else -> RUN; first request for redirect_pc no earlier than next cycle.
REQ-014 FLUSH: imem_req_valid=0; each imem_rsp_valid decrements stale and is discarded; stale reaching 0 -> RUN.
REQ-015 A response arriving in the redirect cycle SHALL be discarded and not counted into stale.
REQ-016 Redirect while in FLUSH SHALL recompute stale as remaining stale minus any discard in that cycle; the target SHALL be the latest redirect_pc.
REQ-017 imem_req_valid MAY drop without handshake only in the cycle following a redirect; otherwise it SHALL stay high and imem_req_addr SHALL stay stable until accepted.
REQ-018 f_valid SHALL be 0 in the cycle after a redirect.

Reset
REQ-019 While reset=0: FSM=BOOT, pc=RESET_PC, FIFOs empty, stale=0, imem_req_valid=0, f_valid=0, f_instr=0, f_pc=0.
REQ-020 Reset assertion mid-transaction SHALL drop all in-flight state; the bench SHALL not return responses for pre-reset requests.

Verification
REQ-021 Reset release, imem always ready, 1-cycle response, f_ready=1 -> addresses 0,4,8,... issued; first f_valid 3 cycles after release with f_pc=0.
REQ-022 f_ready=0 for 10 cycles -> exactly 2 requests issued; head {instr@0, pc 0} held stable; no lost or duplicated instructions on release.
REQ-023 Two requests in flight, redirect_pc=32'h100 -> FLUSH, both responses discarded, next request 32'h100, f_pc=32'h100 delivered.
REQ-024 Redirect in the same cycle as a handshake and a response -> response dropped, handshaken request counted stale, no stale instruction reaches f_*.
REQ-025 RESET_PC=32'hFFFF_FFF8 -> request sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-026 Random imem_req_ready, response delay and f_ready, random redirects -> f_pc sequence matches the reference PC model; the overflow assertion never fires.

Source files
------------

// File: rtl/fetch_unit.sv
// In-order instruction fetch front end. It tracks at most two in-flight requests
// and buffers up to two fetched words, and it flushes responses that belong to the
// old path when a redirect arrives.
module fetch_unit #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        f_valid,
    input  logic        f_ready,
    output logic [31:0] f_instr,
    output logic [31:0] f_pc
);

    localparam logic [2:0] MAX_OUT = 3'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {BOOT, RUN, FLUSH} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ifl_addr_q [2];
    logic [31:0] ifl_addr_d [2];
    logic        ifl_head_q, ifl_head_d;
    logic [1:0]  ifl_cnt_q, ifl_cnt_d;
    logic [31:0] out_instr_q [2];
    logic [31:0] out_instr_d [2];
    logic [31:0] out_pc_q [2];
    logic [31:0] out_pc_d [2];
    logic        out_head_q, out_head_d;
    logic [1:0]  out_cnt_q, out_cnt_d;
    logic [1:0]  stale_q, stale_d;

    logic [2:0]  credit_used;
    logic        req_hs;
    logic        f_pop;
    logic        rsp_keep;
    logic        rsp_drop;

    // Credits cover both in-flight requests and buffered words, so a response always has a slot.
    assign credit_used    = {1'b0, ifl_cnt_q} + {1'b0, out_cnt_q};
    assign imem_req_valid = (state_q == RUN) && (credit_used < MAX_OUT);
    assign imem_req_addr  = pc_q;
    assign req_hs         = imem_req_valid && imem_req_ready;

    assign f_valid = (out_cnt_q != 2'd0);
    assign f_instr = out_instr_q[out_head_q];
    assign f_pc    = out_pc_q[out_head_q];
    assign f_pop   = f_valid && f_ready;

    assign rsp_keep = imem_rsp_valid && !redirect_valid && (stale_q == 2'd0);
    assign rsp_drop = imem_rsp_valid && !redirect_valid && (stale_q != 2'd0);

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ifl_addr_d  = ifl_addr_q;
        ifl_head_d  = ifl_head_q;
        ifl_cnt_d   = ifl_cnt_q;
        out_instr_d = out_instr_q;
        out_pc_d    = out_pc_q;
        out_head_d  = out_head_q;
        out_cnt_d   = out_cnt_q;
        stale_d     = stale_q;

        if (req_hs) begin
            pc_d = pc_q + 32'd4;
            ifl_addr_d[ifl_head_q ^ ifl_cnt_q[0]] = pc_q;
        end
        if (rsp_keep) begin
            ifl_head_d = ~ifl_head_q;
            out_instr_d[out_head_q ^ out_cnt_q[0]] = imem_rsp_data;
            out_pc_d[out_head_q ^ out_cnt_q[0]]    = ifl_addr_q[ifl_head_q];
        end
        ifl_cnt_d = ifl_cnt_q + {1'b0, req_hs} - {1'b0, rsp_keep};

        if (f_pop) begin
            out_head_d = ~out_head_q;
        end
        out_cnt_d = out_cnt_q + {1'b0, rsp_keep} - {1'b0, f_pop};

        if (rsp_drop) begin
            stale_d = stale_q - 2'd1;
        end

        case (state_q)
            BOOT:    state_d = RUN;
            RUN:     state_d = RUN;
            FLUSH:   if (stale_d == 2'd0) state_d = RUN;
            default: state_d = RUN;
        endcase

        // Everything still owed by memory becomes stale, except a response landing right now.
        if (redirect_valid) begin
            pc_d      = redirect_pc;
            ifl_cnt_d = 2'd0;
            out_cnt_d = 2'd0;
            stale_d   = stale_q + ifl_cnt_q + {1'b0, req_hs} - {1'b0, imem_rsp_valid};
            state_d   = (stale_d != 2'd0) ? FLUSH : RUN;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= BOOT;
            pc_q        <= RESET_PC;
            ifl_addr_q  <= '{default: '0};
            ifl_head_q  <= 1'b0;
            ifl_cnt_q   <= 2'd0;
            out_instr_q <= '{default: '0};
            out_pc_q    <= '{default: '0};
            out_head_q  <= 1'b0;
            out_cnt_q   <= 2'd0;
            stale_q     <= 2'd0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ifl_addr_q  <= ifl_addr_d;
            ifl_head_q  <= ifl_head_d;
            ifl_cnt_q   <= ifl_cnt_d;
            out_instr_q <= out_instr_d;
            out_pc_q    <= out_pc_d;
            out_head_q  <= out_head_d;
            out_cnt_q   <= out_cnt_d;
            stale_q     <= stale_d;
        end
    end

    out_fifo_no_overflow: assert property (@(posedge clk) disable iff (!reset)
        !(rsp_keep && (out_cnt_q == 2'd2)));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed and randomized checks for fetch_unit against an independent PC stream
// model and a bench-side in-order instruction memory.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        f_valid, f_ready;
    logic [31:0] f_instr, f_pc;

    logic        r2_valid, r2_ready;
    logic [31:0] r2_addr;
    logic        rsp2_valid;
    logic [31:0] rsp2_data;
    logic        redir2_valid;
    logic [31:0] redir2_pc;
    logic        f2_valid, f2_ready;
    logic [31:0] f2_instr, f2_pc;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset(reset),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .f_valid(f_valid), .f_ready(f_ready),
        .f_instr(f_instr), .f_pc(f_pc)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk(clk), .reset(reset),
        .imem_req_valid(r2_valid), .imem_req_ready(r2_ready),
        .imem_req_addr(r2_addr), .imem_rsp_valid(rsp2_valid),
        .imem_rsp_data(rsp2_data), .redirect_valid(redir2_valid),
        .redirect_pc(redir2_pc), .f_valid(f2_valid), .f_ready(f2_ready),
        .f_instr(f2_instr), .f_pc(f2_pc)
    );

    int          n_checks, n_fail;
    int          cyc, last_due, hs_count, pop_count, wrap_n;
    bit          rnd_mode, knob_ready, knob_f_ready, knob_redir, wrap_rec;
    int          knob_delay;
    logic [31:0] knob_redir_pc;
    logic [31:0] q_addr[$];
    int          q_due[$];
    logic [31:0] exp_req, exp_f;
    bit          prev_req_pend, prev_redir, prev2_hs;
    logic [31:0] prev2_addr;
    logic [31:0] wrap_log [3];

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic check_bit(input string tag, input logic observed, input logic expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
        end
    endtask

    // One clock cycle: drive inputs, play the memories, then check against the PC model.
    task automatic apply_stimulus();
        int due;
        int dly;
        cyc++;
        if (rnd_mode) begin
            imem_req_ready = 1'($urandom_range(0, 1));
            f_ready        = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 15) == 0);
            redirect_pc    = $urandom() & 32'hFFFF_FFFC;
        end else begin
            imem_req_ready = knob_ready;
            f_ready        = knob_f_ready;
            redirect_valid = knob_redir;
            redirect_pc    = knob_redir_pc;
            knob_redir     = 1'b0;
        end

        if (q_addr.size() > 0 && q_due[0] <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = instr_of(q_addr[0]);
            void'(q_addr.pop_front());
            void'(q_due.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
        end

        rsp2_valid = prev2_hs;
        rsp2_data  = instr_of(prev2_addr);
        if (r2_valid && wrap_rec && wrap_n < 3) begin
            wrap_log[wrap_n] = r2_addr;
            wrap_n++;
        end
        prev2_hs   = r2_valid;
        prev2_addr = r2_addr;

        if (prev_req_pend && !prev_redir) check_bit("req_held_valid", imem_req_valid, 1'b1);
        if (prev_redir) check_bit("f_valid_after_redirect", f_valid, 1'b0);
        if (imem_req_valid) check_output("req_addr", imem_req_addr, exp_req);
        if (f_valid) begin
            check_output("f_pc", f_pc, exp_f);
            check_output("f_instr", f_instr, instr_of(exp_f));
        end

        if (imem_req_valid && imem_req_ready) begin
            dly = rnd_mode ? int'($urandom_range(1, 3)) : knob_delay;
            due = cyc + dly;
            if (due <= last_due) due = last_due + 1;
            q_addr.push_back(imem_req_addr);
            q_due.push_back(due);
            last_due = due;
            exp_req  = exp_req + 32'd4;
            hs_count++;
        end
        if (f_valid && f_ready) begin
            exp_f = exp_f + 32'd4;
            pop_count++;
        end
        if (redirect_valid) begin
            exp_req = redirect_pc;
            exp_f   = redirect_pc;
        end
        prev_req_pend = imem_req_valid && !imem_req_ready;
        prev_redir    = redirect_valid;
    endtask

    task automatic step_cycle();
        @(posedge clk);
        #1;
        apply_stimulus();
    endtask

    // Asserts reset mid-flight, drops all pending memory traffic, and releases it;
    // on return the bench is in the first cycle after release.
    task automatic do_reset();
        reset          = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        rsp2_valid     = 1'b0;
        rsp2_data      = 32'h0;
        q_addr.delete();
        q_due.delete();
        cyc = -1; last_due = 0; hs_count = 0; pop_count = 0;
        exp_req = 32'h0; exp_f = 32'h0;
        prev_req_pend = 1'b0; prev_redir = 1'b0; prev2_hs = 1'b0; prev2_addr = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check_bit("rst_req_valid", imem_req_valid, 1'b0);
        check_output("rst_req_addr", imem_req_addr, 32'h0000_0000);
        check_bit("rst_f_valid", f_valid, 1'b0);
        check_output("rst_f_instr", f_instr, 32'h0);
        check_output("rst_f_pc", f_pc, 32'h0);
        check_bit("rst_wrap_req_valid", r2_valid, 1'b0);
        check_output("rst_wrap_req_addr", r2_addr, 32'hFFFF_FFF8);
        check_bit("rst_wrap_f_valid", f2_valid, 1'b0);
        check_output("rst_wrap_f_pc", f2_pc, 32'h0);
        check_output("rst_wrap_f_instr", f2_instr, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        apply_stimulus();
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        rnd_mode = 1'b0; knob_ready = 1'b1; knob_f_ready = 1'b1; knob_delay = 1;
        knob_redir = 1'b0; knob_redir_pc = 32'h0;
        r2_ready = 1'b1; f2_ready = 1'b1; redir2_valid = 1'b0; redir2_pc = 32'h0;
        imem_req_ready = 1'b1; f_ready = 1'b1;
        wrap_rec = 1'b1; wrap_n = 0;
        wrap_log = '{default: '0};
        $display("[TB] fetch_unit bench start");

        // Streaming with 1-cycle memory and an always-ready consumer.
        do_reset();
        check_bit("boot_no_req", imem_req_valid, 1'b0);
        check_bit("boot_f_valid", f_valid, 1'b0);
        step_cycle();
        check_bit("c1_req_valid", imem_req_valid, 1'b1);
        check_output("c1_req_addr", imem_req_addr, 32'h0);
        step_cycle();
        check_bit("c2_req_valid", imem_req_valid, 1'b1);
        check_output("c2_req_addr", imem_req_addr, 32'h4);
        check_bit("c2_f_valid", f_valid, 1'b0);
        step_cycle();
        check_bit("c3_f_valid", f_valid, 1'b1);
        check_output("c3_f_pc", f_pc, 32'h0);
        check_output("c3_f_instr", f_instr, 32'hDEAD_BEEF);
        repeat (10) step_cycle();
        check_output("wrap_addr0", wrap_log[0], 32'hFFFF_FFF8);
        check_output("wrap_addr1", wrap_log[1], 32'hFFFF_FFFC);
        check_output("wrap_addr2", wrap_log[2], 32'h0000_0000);
        wrap_rec = 1'b0;

        // Consumer stalled for ten cycles: only two credits' worth of requests.
        knob_f_ready = 1'b0;
        do_reset();
        repeat (10) step_cycle();
        check_output("stall_req_count", 32'(hs_count), 32'd2);
        check_bit("stall_req_valid", imem_req_valid, 1'b0);
        check_bit("stall_f_valid", f_valid, 1'b1);
        check_output("stall_f_pc", f_pc, 32'h0);
        check_output("stall_f_instr", f_instr, 32'hDEAD_BEEF);
        knob_f_ready = 1'b1;
        step_cycle();
        step_cycle();
        check_output("unstall_f_pc", f_pc, 32'h4);
        check_output("unstall_req_addr", imem_req_addr, 32'h8);
        repeat (6) step_cycle();

        // Redirect with two requests outstanding on a slow memory.
        knob_delay = 4;
        do_reset();
        step_cycle();
        step_cycle();
        knob_redir = 1'b1; knob_redir_pc = 32'h100;
        step_cycle();
        step_cycle();
        check_bit("flush_c4_req_valid", imem_req_valid, 1'b0);
        check_bit("flush_c4_f_valid", f_valid, 1'b0);
        step_cycle();
        step_cycle();
        check_bit("flush_c6_req_valid", imem_req_valid, 1'b0);
        step_cycle();
        check_bit("redir_req_valid", imem_req_valid, 1'b1);
        check_output("redir_req_addr", imem_req_addr, 32'h100);
        for (int k = 0; k < 20 && !f_valid; k++) step_cycle();
        check_bit("redir_deliver_valid", f_valid, 1'b1);
        check_output("redir_deliver_pc", f_pc, 32'h100);
        check_output("redir_deliver_instr", f_instr, 32'hDEAD_BFEF);

        // Redirect coinciding with a handshake and a response.
        knob_delay = 1;
        do_reset();
        step_cycle();
        knob_redir = 1'b1; knob_redir_pc = 32'h200;
        step_cycle();
        check_bit("same_cycle_req_valid", imem_req_valid, 1'b1);
        step_cycle();
        check_bit("same_c3_req_valid", imem_req_valid, 1'b0);
        check_bit("same_c3_f_valid", f_valid, 1'b0);
        step_cycle();
        check_bit("same_c4_req_valid", imem_req_valid, 1'b1);
        check_output("same_c4_req_addr", imem_req_addr, 32'h200);
        check_bit("same_c4_f_valid", f_valid, 1'b0);
        step_cycle();
        check_bit("same_c5_f_valid", f_valid, 1'b0);
        step_cycle();
        check_bit("same_c6_f_valid", f_valid, 1'b1);
        check_output("same_c6_f_pc", f_pc, 32'h200);
        check_output("same_c6_f_instr", f_instr, 32'hDEAD_BCEF);

        // Second redirect during FLUSH retargets and re-counts the stale responses.
        knob_delay = 4;
        do_reset();
        step_cycle();
        step_cycle();
        knob_redir = 1'b1; knob_redir_pc = 32'h100;
        step_cycle();
        step_cycle();
        knob_redir = 1'b1; knob_redir_pc = 32'h300;
        step_cycle();
        step_cycle();
        check_bit("reflush_c6_req_valid", imem_req_valid, 1'b0);
        step_cycle();
        check_bit("reflush_c7_req_valid", imem_req_valid, 1'b1);
        check_output("reflush_c7_req_addr", imem_req_addr, 32'h300);

        // Random ready, latency, consumer back-pressure and redirects.
        rnd_mode = 1'b1;
        do_reset();
        repeat (3000) step_cycle();
        rnd_mode = 1'b0;
        check_bit("rand_progress", (pop_count > 50), 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
